// File: rtl/if_pkg.sv
// Shared types for the IF-stage fetch controller: FSM states, the fetch entry
// handed to the IF/ID boundary, and small helpers.
package if_pkg;

  localparam int IF_ADDR_W = 32;
  localparam int IF_INST_W = 32;

  localparam logic [IF_INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_INST_W-1:0] inst;
    logic                 adel;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] pc_low);
    return pc_low != 2'b00;
  endfunction

endpackage

// File: rtl/if_out_buf.sv
// Registered IF/ID output slot backed by a single skid entry; the skid refills
// the slot in the same cycle the slot is consumed.
module if_out_buf
  import if_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         consume_i,
  input  logic         flush_i,
  output fetch_entry_t slot_o,
  output logic         slot_valid_o,
  output logic         skid_valid_o,
  output logic         skid_valid_next_o
);

  fetch_entry_t slot_q, slot_d;
  fetch_entry_t skid_q, skid_d;
  logic         slot_valid_q, slot_valid_d;
  logic         skid_valid_q, skid_valid_d;

  // Only one fetch is ever outstanding, so a push never meets a full skid
  // while the slot is held.
  always_comb begin
    slot_d       = slot_q;
    skid_d       = skid_q;
    slot_valid_d = slot_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!slot_valid_q || consume_i) begin
      if (skid_valid_q) begin
        slot_d       = skid_q;
        slot_valid_d = 1'b1;
        skid_valid_d = push_i;
        if (push_i) skid_d = entry_i;
      end else begin
        slot_valid_d = push_i;
        if (push_i) slot_d = entry_i;
      end
    end else if (push_i) begin
      skid_d       = entry_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q       <= '0;
      skid_q       <= '0;
      slot_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      skid_q       <= skid_d;
      slot_valid_q <= slot_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign slot_o            = slot_q;
  assign slot_valid_o      = slot_valid_q;
  assign skid_valid_o      = skid_valid_q;
  assign skid_valid_next_o = skid_valid_d;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// IF-stage fetch controller: one SRAM-like request at a time, flush/discard of
// in-flight data, PC back-pressure. IF_FETCH_PERF_EN adds perf counters.
module inst_fetch_ctrl
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              inst_req_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  input  logic              inst_addr_ok_i,
  input  logic              inst_data_ok_i,
  input  logic [INST_W-1:0] inst_rdata_i,
  output logic              pc_stall_o,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_adel_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic         misaligned;
  logic         req_ok;
  logic         accept;
  logic         pseudo_fetch;
  logic         data_hit;
  logic         push;
  logic         consume;
  fetch_entry_t push_entry;
  fetch_entry_t slot;
  logic         slot_valid;
  logic         skid_valid;
  logic         skid_valid_next;

  // A held skid blocks both real requests and the misaligned pseudo-fetch,
  // since either would need somewhere to land.
  always_comb begin
    misaligned   = is_misaligned(pc_i[1:0]);
    req_ok       = (state_q == REQ) && ce_i && !skid_valid;
    inst_req_o   = req_ok && !misaligned;
    accept       = inst_req_o && inst_addr_ok_i && !flush_i;
    pseudo_fetch = req_ok && misaligned && !flush_i;
    data_hit     = (state_q == WAIT_DATA) && inst_data_ok_i && !flush_i;
    push         = data_hit || pseudo_fetch;
    pc_stall_o   = !(accept || pseudo_fetch);
    consume      = slot_valid && !stall_i;
    if (pseudo_fetch) begin
      push_entry.pc   = IF_ADDR_W'(pc_i);
      push_entry.inst = ZERO_WORD;
      push_entry.adel = 1'b1;
    end else begin
      push_entry.pc   = IF_ADDR_W'(req_pc_q);
      push_entry.inst = IF_INST_W'(inst_rdata_i);
      push_entry.adel = 1'b0;
    end
  end

  assign inst_addr_o = pc_i;

  // A response that lands in the flush cycle closes the transaction, so
  // WAIT_DATA only parks in DISCARD when the data is still to come.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      IDLE: begin
        if (ce_i && !skid_valid) state_d = REQ;
      end
      REQ: begin
        if (flush_i) begin
          if (inst_req_o && inst_addr_ok_i) state_d = DISCARD;
        end else if (accept) begin
          req_pc_d = pc_i;
          state_d  = WAIT_DATA;
        end else if (!ce_i) begin
          state_d = IDLE;
        end
      end
      WAIT_DATA: begin
        if (inst_data_ok_i) begin
          state_d = (ce_i && !skid_valid_next) ? REQ : IDLE;
        end else if (flush_i) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (inst_data_ok_i) state_d = (ce_i && !skid_valid_next) ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  if_out_buf u_out_buf (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .push_i            (push),
    .entry_i           (push_entry),
    .consume_i         (consume),
    .flush_i           (flush_i),
    .slot_o            (slot),
    .slot_valid_o      (slot_valid),
    .skid_valid_o      (skid_valid),
    .skid_valid_next_o (skid_valid_next)
  );

  assign if_valid_o = slot_valid;
  assign if_pc_o    = ADDR_W'(slot.pc);
  assign if_inst_o  = INST_W'(slot.inst);
  assign if_adel_o  = slot.adel;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(push);
    stall_cnt_d = stall_cnt_q + 32'(pc_stall_o && ce_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
